// File: rtl/bus_sram_target.sv
`default_nettype none
// ============================================================================
// Module   : bus_sram_target
// Purpose  : Main-bus memory target. A single-ported on-chip SRAM serving
//            4-beat, line-aligned write and read bursts. Commands outside the
//            mapped window are reported on sram_error and held until
//            bmain_eack.
// Ports    : clk_core, reset_n (async, active-low)
//            command : bmain_cvalid/sram_cready, bmain_cmd (1=read),
//                      bmain_addr (word address [28:2])
//            write   : bmain_wvalid/sram_wready, bmain_wlast, bmain_wdata,
//                      bmain_wmask (byte enables)
//            read    : sram_rvalid/bmain_rready, sram_rlast, sram_rdata
//            error   : sram_error/bmain_eack
// Revision : 1.0 - initial release
// ============================================================================
module bus_sram_target #(
  parameter logic [26:0] BASE_WADDR  = 27'h0,
  parameter int          DEPTH_LINES = 1024,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        bmain_cvalid,
  output logic        sram_cready,
  input  logic        bmain_cmd,
  input  logic [26:0] bmain_addr,
  input  logic        bmain_wvalid,
  output logic        sram_wready,
  input  logic        bmain_wlast,
  input  logic [31:0] bmain_wdata,
  input  logic [3:0]  bmain_wmask,
  output logic        sram_rvalid,
  input  logic        bmain_rready,
  output logic        sram_rlast,
  output logic [31:0] sram_rdata,
  output logic        sram_error,
  input  logic        bmain_eack
);

  localparam int          C_LINE_W    = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int          C_WORD_W    = C_LINE_W + 2;
  localparam int          C_WORDS     = 4 * DEPTH_LINES;
  // Upper bound kept one bit wider than the address so the window end never wraps.
  localparam logic [27:0] C_LIMIT     = {1'b0, BASE_WADDR} + 28'(4 * DEPTH_LINES);
  localparam logic [3:0]  C_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_RWAIT  = 3'd2,
    S_READ   = 3'd3,
    S_WDRAIN = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t                r_state, w_state_next;
  logic [1:0]            r_cnt, w_cnt_next;
  logic [C_LINE_W-1:0]   r_line, w_line_next;
  logic [3:0]            r_wait, w_wait_next;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [C_WORDS];

  logic [26:0]           w_line_waddr;
  logic [27:0]           w_rel;
  logic                  w_hit;
  logic [C_LINE_W-1:0]   w_line_idx;
  logic                  w_wr_en;
  logic [C_WORD_W-1:0]   w_wr_addr;
  logic                  w_rd_en;
  logic [C_WORD_W-1:0]   w_rd_addr;
  logic                  w_unused;

  // Range check on the line-aligned address. The borrow out of the 28-bit
  // subtraction flags addresses below the base.
  assign w_line_waddr = {bmain_addr[26:2], 2'b00};
  assign w_rel        = {1'b0, w_line_waddr} - {1'b0, BASE_WADDR};
  assign w_hit        = ~w_rel[27] && ({1'b0, w_line_waddr} < C_LIMIT);
  assign w_line_idx   = w_rel[C_WORD_W-1:2];
  assign w_unused     = ^{w_rel, bmain_addr[1:0]};

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_line  <= '0;
      r_wait  <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_line  <= w_line_next;
      r_wait  <= w_wait_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_line_next  = r_line;
    w_wait_next  = r_wait;
    sram_cready  = 1'b0;
    sram_wready  = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_addr    = {r_line, r_cnt};
    w_rd_en      = 1'b0;
    w_rd_addr    = {r_line, 2'b00};

    case (r_state)
      S_IDLE: begin
        sram_cready = 1'b1;
        // The first write beat travels with the command.
        sram_wready = bmain_cvalid & ~bmain_cmd;
        if (bmain_cvalid) begin
          if (!bmain_cmd) begin
            if (w_hit) begin
              w_line_next = w_line_idx;
              w_cnt_next  = 2'd0;
              if (bmain_wvalid) begin
                w_wr_en   = 1'b1;
                w_wr_addr = {w_line_idx, 2'b00};
                if (bmain_wlast) begin
                  w_state_next = S_ERROR;
                end else begin
                  w_state_next = S_WRITE;
                  w_cnt_next   = 2'd1;
                end
              end else begin
                w_state_next = S_WRITE;
              end
            end else begin
              w_state_next = (bmain_wvalid && bmain_wlast) ? S_ERROR : S_WDRAIN;
            end
          end else begin
            if (w_hit) begin
              w_line_next = w_line_idx;
              w_cnt_next  = 2'd0;
              if (WAIT_CYCLES == 0) begin
                // No wait: fetch word 0 now so it is on rdata next cycle.
                w_rd_en      = 1'b1;
                w_rd_addr    = {w_line_idx, 2'b00};
                w_state_next = S_READ;
              end else begin
                w_wait_next  = C_WAIT_LOAD;
                w_state_next = S_RWAIT;
              end
            end else begin
              w_state_next = S_ERROR;
            end
          end
        end
      end

      S_WRITE: begin
        sram_wready = 1'b1;
        if (bmain_wvalid) begin
          // A badly framed beat is still written before reporting the error.
          w_wr_en = 1'b1;
          if (r_cnt == 2'd3) begin
            w_cnt_next   = 2'd0;
            w_state_next = bmain_wlast ? S_IDLE : S_ERROR;
          end else if (bmain_wlast) begin
            w_cnt_next   = 2'd0;
            w_state_next = S_ERROR;
          end else begin
            w_cnt_next = r_cnt + 2'd1;
          end
        end
      end

      S_WDRAIN: begin
        sram_wready = 1'b1;
        if (bmain_wvalid && bmain_wlast) begin
          w_state_next = S_ERROR;
        end
      end

      S_RWAIT: begin
        if (r_wait == 4'd0) begin
          w_rd_en      = 1'b1;
          w_state_next = S_READ;
        end else begin
          w_wait_next = r_wait - 4'd1;
        end
      end

      S_READ: begin
        if (bmain_rready) begin
          if (r_cnt == 2'd3) begin
            w_cnt_next   = 2'd0;
            w_state_next = S_IDLE;
          end else begin
            // Prefetch the next word so it appears right as the beat completes.
            w_cnt_next = r_cnt + 2'd1;
            w_rd_en    = 1'b1;
            w_rd_addr  = {r_line, r_cnt + 2'd1};
          end
        end
      end

      S_ERROR: begin
        if (bmain_eack) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk_core) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bmain_wmask[b]) begin
          r_mem[w_wr_addr][8*b +: 8] <= bmain_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read data register only loads on a fetch, so it holds under backpressure.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= 32'd0;
    end else if (w_rd_en) begin
      r_rdata <= r_mem[w_rd_addr];
    end
  end

  assign sram_rvalid = (r_state == S_READ);
  assign sram_rlast  = (r_state == S_READ) && (r_cnt == 2'd3);
  assign sram_rdata  = r_rdata;
  assign sram_error  = (r_state == S_ERROR);

endmodule
`default_nettype wire

// File: doc/bus_sram_target.md
# bus_sram_target

Responder end of the main-bus protocol: a single-ported on-chip SRAM that accepts line commands from a bus initiator (the memory stage's cache-fill/evict engine) and serves 4-beat, line-aligned write and read bursts. It sits behind the main bus arbiter as a memory target. Out-of-range accesses are reported through the error/eack handshake.

## Interface
- `BASE_WADDR`, default 27'h0: word address (addr[28:2]) of first SRAM word.
- `DEPTH_LINES`, default 1024: SRAM size in 16-byte lines; power of two.
- `WAIT_CYCLES`, default 0: extra idle cycles between read command accept and first rvalid (0..15).
- Clocking: one clock, `clk_core`; reset `reset_n` is asynchronous, active-low.
- `clk_core` in 1: core clock.
- `reset_n` in 1: async active-low reset.
- `bmain_cvalid` in 1: command valid.
- `sram_cready` out 1: command ready.
- `bmain_cmd` in 1: 1 = read burst, 0 = write burst.
- `bmain_addr` in 27: word address [28:2]; bits [3:2] ignored (bursts line-aligned).
- `bmain_wvalid` in 1: write beat valid.
- `sram_wready` out 1: write beat ready.
- `bmain_wlast` in 1: final write beat.
- `bmain_wdata` in 32: write data.
- `bmain_wmask` in 4: byte enables; bit i writes byte i.
- `sram_rvalid` out 1: read beat valid.
- `bmain_rready` in 1: read beat ready.
- `sram_rlast` out 1: final read beat.
- `sram_rdata` out 32: read data.
- `sram_error` out 1: access error.
- `bmain_eack` in 1: error acknowledge.

## Operation
- States: IDLE, WRITE, RWAIT, READ, WDRAIN, ERROR. Reset -> IDLE, beat counter 0, rvalid/rlast/error 0, rdata 0. SRAM contents not reset.
- Range check: hit iff BASE_WADDR <= {addr[28:4],2'b00} < BASE_WADDR + 4*DEPTH_LINES; 27-bit unsigned compare, no wrap.
- IDLE: cready = 1. wready = cvalid & ~cmd (first write beat accepted in same cycle as command; initiator issues cvalid and first wvalid together).
  - write hit: beat 0 written at line offset 0 if wvalid; -> WRITE with counter 1 (counter 0 if wvalid low).
  - write miss: -> WDRAIN, beat data discarded.
  - read hit: latch line address; -> RWAIT (WAIT_CYCLES>0) else READ.
  - read miss: -> ERROR.
- WRITE: wready = 1. Each wvalid beat writes offset = counter under wmask; counter++. Beat with counter==3 must carry wlast -> IDLE. wlast on counter<3, or missing on counter==3: beat still written, -> ERROR.
- WDRAIN: wready = 1, discard beats until wlast -> ERROR.
- RWAIT: count WAIT_CYCLES, -> READ; SRAM read of offset 0 issued on last wait cycle.
- READ: rvalid = 1, rdata = word at offset counter (0..3 in order), rlast = (counter==3). Beat completes on rvalid&rready: counter++, next word prefetched; rdata/rvalid held stable while rready low. rlast beat completes -> IDLE, rvalid 0.
- ERROR: error = 1, cready = wready = rvalid = 0. eack high -> IDLE next cycle, error 0. cvalid in ERROR ignored (not accepted).
- Counter wraps 3->0 only on leaving WRITE/READ; reset to 0 on entering any burst.

## Timing
- Write: 4 beats in minimum 4 cycles (cycle 0 = command+beat 0); cready high again cycle 4.
- Read: command handshake cycle T; first rvalid cycle T+1+WAIT_CYCLES; with rready held high, beats on consecutive cycles, rlast at T+4+WAIT_CYCLES; cready high the cycle after.
- Read miss: error high at T+1; held until eack sampled; eack combinationally tied to error by initiator gives 1-cycle pulse.
- SRAM: one synchronous read port, one write port; no read-during-write hazard (bursts non-overlapping).
- Async reset mid-burst: all outputs to reset values immediately; partial write burst leaves already-written words modified.

## Test plan
- Write hit: addr 27'h10 (line 4), wdata 11,22,33,44, wmask 'hF, wlast on beat 3 -> wready 4 cycles, cready back in cycle 4; read back returns 11,22,33,44 with rlast on 4th.
- Byte masks: write 'hAABBCCDD mask 'b0101 over 'h0 -> read returns 'h00BB00DD for that word.
- Read backpressure, WAIT_CYCLES=2: rready low 3 cycles on beat 1 -> rdata stable, first rvalid at T+3, 4 beats in order.
- Out-of-range read (addr = BASE + 4*DEPTH_LINES) -> no rvalid, error at T+1, cleared after eack; next command accepted.
- Early wlast on beat 1 -> beats 0,1 written, error asserted, beats 2,3 untouched.
- Assert reset_n low mid read burst (beat 2) -> rvalid/rlast/error 0 same cycle, cready 1 after release, SRAM data intact.
